// File: rtl/barrel_shift_seq_pkg.sv
// Shared definitions for the sequential barrel shifter: operation encodings
// and the controller state type.
package barrel_shift_seq_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t ROL = 2'b00;
  localparam mode_t SLL = 2'b01;
  localparam mode_t ROR = 2'b10;
  localparam mode_t SRA = 2'b11;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

endpackage

// File: rtl/barrel_shift_seq_shift_stage.sv
// One combinational barrel stage: moves the word by 2^idx positions in the
// selected mode when enabled, otherwise passes it through.
module shift_stage
  import barrel_shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] idx,
  input  logic                     en,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         result
);

  localparam int STAGES = $clog2(WIDTH);

  logic [STAGES:0] amt_s;
  logic [STAGES:0] inv_s;

  // Stage distance is at most WIDTH/2, so the complementary rotate distance is never zero.
  always_comb begin
    amt_s  = {{STAGES{1'b0}}, 1'b1} << idx;
    inv_s  = (STAGES+1)'(WIDTH) - amt_s;
    result = data;
    if (en) begin
      case (mode)
        ROL:     result = (data << amt_s) | (data >> inv_s);
        SLL:     result = data << amt_s;
        ROR:     result = (data >> amt_s) | (data << inv_s);
        SRA:     result = $signed(data) >>> amt_s;
        default: result = data;
      endcase
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/barrel_shift_seq.sv
// Sequential barrel shifter: applies one power-of-two stage per clock using a
// single shared shift_stage, publishing the result only on completion.
module barrel_shift_seq
  import barrel_shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(WIDTH)-1:0] cnt,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         out,
  output logic                     busy,
  output logic                     done
);

  localparam int STAGES = $clog2(WIDTH);
  localparam logic [STAGES-1:0] LAST_K = STAGES'(STAGES - 1);

  state_t            state_r;
  logic [STAGES-1:0] k_r;
  logic [STAGES-1:0] cnt_r;
  logic [1:0]        mode_r;
  logic [WIDTH-1:0]  work_r;
  logic [WIDTH-1:0]  out_r;
  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  stage_s;

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .data   (work_r),
    .idx    (k_r),
    .en     (cnt_r[k_r]),
    .mode   (mode_r),
    .result (stage_s)
  );

  // Controller, capture registers and result register; busy/done are registered alongside state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= {STAGES{1'b0}};
      cnt_r   <= {STAGES{1'b0}};
      mode_r  <= 2'b00;
      work_r  <= {WIDTH{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            work_r  <= in;
            cnt_r   <= cnt;
            mode_r  <= mode;
            k_r     <= {STAGES{1'b0}};
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          work_r <= stage_s;
          k_r    <= k_r + {{(STAGES-1){1'b0}}, 1'b1};
          if (k_r == LAST_K) begin
            out_r   <= stage_s;
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Self-checking bench for barrel_shift_seq: directed vectors with literal
// expectations plus a randomized run checked every cycle against a timing model.
module tb_barrel_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic [1:0]  mode;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  barrel_shift_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .cnt   (cnt),
    .mode  (mode),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full shift by c positions, one bit at a time.
  function automatic logic [15:0] ref_fn(input logic [15:0] x, input logic [3:0] c,
                                         input logic [1:0] m);
    logic [15:0] r;
    r = x;
    for (int i = 0; i < int'(c); i++) begin
      case (m)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {r[15], r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Timing model: an op accepted at edge e is busy after edges e..e+3 and done after e+4.
  int          cyc     = 0;
  int          acc     = 0;
  bit          have_op = 1'b0;
  logic [15:0] pend    = 16'h0000;
  logic [15:0] m_out   = 16'h0000;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_op = 1'b0;
      m_out   = 16'h0000;
      m_busy  = 1'b0;
      m_done  = 1'b0;
    end else begin
      if (start && !m_busy) begin
        have_op = 1'b1;
        acc     = cyc;
        pend    = ref_fn(in, cnt, mode);
      end
      m_busy = have_op && ((cyc - acc) < 4);
      m_done = have_op && ((cyc - acc) == 4);
      if (m_done) m_out = pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
      chk("model_out", int'(out), int'(m_out));
    end
  end

  // Issue one op; optionally scramble inputs while busy. Returns negedges until done.
  task automatic do_op(input string nm, input logic [15:0] d, input logic [3:0] c,
                       input logic [1:0] m, input logic [15:0] exp, input bit scramble,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; in = d; cnt = c; mode = m;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 12) begin
      busy_cnt += int'(busy);
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        in    = 16'($urandom);
        cnt   = 4'($urandom);
        mode  = 2'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (lat >= 12) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_out"}, int'(out), int'(exp));
  endtask

  int lat, bc, gap, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; in = 16'h0000; cnt = 4'h0; mode = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    chk("pin_rol", int'(ref_fn(16'h8001, 4'd1, 2'b00)), 16'h0003);
    chk("pin_sll", int'(ref_fn(16'h00FF, 4'd8, 2'b01)), 16'hFF00);
    chk("pin_ror", int'(ref_fn(16'h1234, 4'd4, 2'b10)), 16'h4123);
    chk("pin_sra", int'(ref_fn(16'h8000, 4'd15, 2'b11)), 16'hFFFF);

    do_op("rol1", 16'h8001, 4'd1, 2'b00, 16'h0003, 1'b0, lat, bc);
    chk("rol1_latency", lat, 4);
    chk("rol1_busy_cycles", bc, 4);
    do_op("sll8", 16'h00FF, 4'd8, 2'b01, 16'hFF00, 1'b0, lat, bc);
    do_op("sra15", 16'h8000, 4'd15, 2'b11, 16'hFFFF, 1'b0, lat, bc);
    do_op("sra14", 16'h4000, 4'd14, 2'b11, 16'h0001, 1'b0, lat, bc);
    do_op("ror4", 16'h1234, 4'd4, 2'b10, 16'h4123, 1'b0, lat, bc);
    for (int m = 0; m < 4; m++) begin
      do_op("cnt0", 16'hA5C3, 4'd0, 2'(m), 16'hA5C3, 1'b0, lat, bc);
      chk("cnt0_latency", lat, 4);
    end
    do_op("scramble", 16'hC001, 4'd3, 2'b10, 16'h3800, 1'b1, lat, bc);
    chk("scramble_latency", lat, 4);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start = 1'b1; in = 16'h0F00; cnt = 4'd4; mode = 2'b01;
    n = 0;
    @(negedge clk);
    while (!done && n < 12) begin @(negedge clk); n++; end
    chk("b2b_first_out", int'(out), 16'hF000);
    in = 16'h8421; cnt = 4'd1; mode = 2'b10;
    gap = 0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", int'(busy), 1);
    gap = 1;
    while (!done && gap < 12) begin @(negedge clk); gap++; end
    chk("b2b_spacing", gap, 5);
    chk("b2b_second_out", int'(out), 16'hC210);

    // Reset two cycles after start aborts the op.
    @(negedge clk);
    start = 1'b1; in = 16'h1111; cnt = 4'd2; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out", int'(out), 0);
    chk("abort_busy", int'(busy), 0);
    start = 1'b1;
    @(negedge clk);
    chk("abort_start_ignored", int'(busy), 0);
    rst_n = 1'b1; start = 1'b0;
    bc = 0;
    repeat (6) begin @(negedge clk); bc += int'(done); end
    chk("abort_no_done", bc, 0);
    do_op("rol15", 16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0, lat, bc);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      in    = 16'($urandom);
      cnt   = 4'($urandom);
      mode  = 2'($urandom);
      rst_n = ($urandom_range(0, 59) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_shift_seq.md
BARREL_SHIFT_SEQ -- requirements
Module: barrel_shift_seq

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width and SHALL be a power of two, minimum 4.
REQ-002 Localparam STAGES SHALL equal log2(WIDTH), which is 4 at the default width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 start  input  1  SHALL request an operation; it is sampled only when the block is not busy.
REQ-006 in  input  WIDTH  SHALL be the operand, captured with start.
REQ-007 cnt  input  STAGES  SHALL be the shift/rotate amount, captured with start.
REQ-008 mode  input  2  SHALL select the operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA; captured with start.
REQ-009 out  output  WIDTH  SHALL be the registered result, held until the next completion.
REQ-010 busy  output  1  SHALL be high while an operation is in progress.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking the cycle in which out first shows a new result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL:
- capture in, cnt and mode into internal registers;
- clear the stage index k to 0;
- enter RUN.
REQ-014 In RUN, each rising edge SHALL apply stage k and then increment k. Stage k:
- if cnt[k]=1, shift or rotate the working register by 2^k positions in the captured mode;
- if cnt[k]=0, pass the working register unchanged.
REQ-015 The edge that applies stage STAGES-1 SHALL load out with the final value and enter DONE.
REQ-016 done SHALL be high only in DONE; DONE SHALL last exactly one cycle.
REQ-017 If start=0 in DONE, the next state SHALL be IDLE.
REQ-018 busy SHALL be high exactly in RUN.
REQ-019 Latency: start sampled at edge 0 SHALL give done=1 in the cycle after edge STAGES, i.e. 5 cycles after the start cycle at WIDTH=16.
REQ-020 Latency SHALL be fixed and independent of cnt and mode, including cnt=0.
REQ-021 Per-mode behaviour:
- ROL and ROR SHALL wrap bits around the word;
- SLL SHALL fill vacated low bits with 0;
- SRA SHALL fill vacated high bits with the sign bit of the captured in.
REQ-022 Changes to start, in, cnt or mode while busy=1 SHALL be ignored; the operation in flight SHALL be unaffected.
REQ-023 start=1 in the DONE cycle SHALL begin a new operation back-to-back, with no idle cycle between operations.
REQ-024 out SHALL change only on the edge entering DONE, or on reset; intermediate working values SHALL never appear on out.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL go to IDLE and set out=0, busy=0, done=0, k=0 and clear the working register.
REQ-026 Reset during RUN SHALL abort the operation: no done pulse and no update of out.
REQ-027 start SHALL be ignored in any cycle where rst_n=0.
REQ-028 The first start after reset is released SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold:
- the mode encoding constants ROL, SLL, ROR, SRA;
- the FSM state typedef.
REQ-030 A single combinational sub-module, shift_stage, SHALL implement one stage. It SHALL be parametrised by WIDTH and take the data, a stage-index amount, an enable bit and the mode.
REQ-031 barrel_shift_seq SHALL contain one shift_stage instance, selected by k, plus the FSM, the capture registers and the out register.
REQ-032 No combinational path SHALL exist from any input to any output.

Verification
REQ-033 WIDTH=16, ROL, in=0x8001, cnt=1 -> done after 5 cycles, out=0x0003, busy high for exactly 4 cycles.
REQ-034 SLL, in=0x00FF, cnt=8 -> out=0xFF00; SRA, in=0x8000, cnt=15 -> out=0xFFFF; SRA, in=0x4000, cnt=14 -> out=0x0001.
REQ-035 ROR, in=0x1234, cnt=4 -> out=0x4123; cnt=0 in any mode -> out=in, done still 5 cycles after start.
REQ-036 Change in, cnt and mode and toggle start while busy -> result matches the originally captured values; start held high in DONE -> next result follows with no gap cycle.
REQ-037 rst_n=0 two cycles after start -> out=0, busy=0, no done pulse; a following ROL of 0x0001 with cnt=15 -> out=0x8000.
